// File: rtl/comparator_probe_ctrl.sv
// Initiator-side controller for a shared SEL-programmable comparator: issues an eq probe,
// then a ge probe if needed, and decodes the answers into {gt,eq,lt} plus min/max.
module comparator_probe_ctrl #(
    parameter int unsigned N       = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         cmp_req,
    output logic [2:0]   cmp_sel,
    output logic [N-1:0] cmp_value1,
    output logic [N-1:0] cmp_value2,
    input  logic         cmp_rsp_valid,
    input  logic         cmp_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   out_rel,
    output logic [N-1:0] out_max,
    output logic [N-1:0] out_min,
    output logic         out_err,
    output logic [1:0]   out_probes
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    localparam logic [2:0] SelZero = 3'b000;
    localparam logic [2:0] SelEq   = 3'b010;
    localparam logic [2:0] SelGe   = 3'b100;

    typedef enum logic [2:0] {
        StIdle,
        StProbeEq,
        StWaitEq,
        StProbeGe,
        StWaitGe,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic [2:0]      rel_q, rel_d;
    logic [N-1:0]    max_q, max_d;
    logic [N-1:0]    min_q, min_d;
    logic            err_q, err_d;
    logic [1:0]      probes_q, probes_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            rel_q    <= '0;
            max_q    <= '0;
            min_q    <= '0;
            err_q    <= 1'b0;
            probes_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            rel_q    <= rel_d;
            max_q    <= max_d;
            min_q    <= min_d;
            err_q    <= err_d;
            probes_q <= probes_d;
        end
    end

    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        rel_d    = rel_q;
        max_d    = max_q;
        min_d    = min_q;
        err_d    = err_q;
        probes_d = probes_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = StProbeEq;
                end
            end
            StProbeEq: begin
                cnt_d   = '0;
                state_d = StWaitEq;
            end
            StWaitEq: begin
                // A response in the timeout cycle still wins.
                if (cmp_rsp_valid) begin
                    if (cmp_out) begin
                        rel_d    = 3'b010;
                        max_d    = a_q;
                        min_d    = b_q;
                        err_d    = 1'b0;
                        probes_d = 2'd1;
                        state_d  = StDone;
                    end else begin
                        state_d = StProbeGe;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntLast) begin
                        rel_d    = 3'b000;
                        max_d    = '0;
                        min_d    = '0;
                        err_d    = 1'b1;
                        probes_d = 2'd1;
                        state_d  = StDone;
                    end
                end
            end
            StProbeGe: begin
                cnt_d   = '0;
                state_d = StWaitGe;
            end
            StWaitGe: begin
                if (cmp_rsp_valid) begin
                    err_d    = 1'b0;
                    probes_d = 2'd2;
                    state_d  = StDone;
                    if (cmp_out) begin
                        rel_d = 3'b100;
                        max_d = a_q;
                        min_d = b_q;
                    end else begin
                        rel_d = 3'b001;
                        max_d = b_q;
                        min_d = a_q;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntLast) begin
                        rel_d    = 3'b000;
                        max_d    = '0;
                        min_d    = '0;
                        err_d    = 1'b1;
                        probes_d = 2'd2;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        cmp_req   = 1'b0;
        cmp_sel   = SelZero;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle:    in_ready = 1'b1;
            StProbeEq: begin
                cmp_req = 1'b1;
                cmp_sel = SelEq;
            end
            StWaitEq:  cmp_sel = SelEq;
            StProbeGe: begin
                cmp_req = 1'b1;
                cmp_sel = SelGe;
            end
            StWaitGe:  cmp_sel = SelGe;
            StDone:    out_valid = 1'b1;
            default:   in_ready = 1'b0;
        endcase
    end

    assign cmp_value1 = a_q;
    assign cmp_value2 = b_q;
    assign out_rel    = rel_q;
    assign out_max    = max_q;
    assign out_min    = min_q;
    assign out_err    = err_q;
    assign out_probes = probes_q;

endmodule
